pipeline_stage_reg: RTL and testbench

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

---
 rtl/pipeline_stage_reg.sv | 130 +++++++++++++
 tb/tb_pipeline_stage_reg.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_reg.sv
// Pipeline stage register with valid/ready handshake, bubble insertion, flush and a flag register.
// Define PIPE_SKID_EN for a two-entry skid buffer (registered in_ready); default is a single entry.
module pipeline_stage_reg #(
   parameter int DATA_W = 16,
   parameter int CTRL_W = 8,
   parameter int FLAG_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_nop,
   input  logic [CTRL_W-1:0]   in_ctrl,
   input  logic [2*DATA_W-1:0] in_data,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CTRL_W-1:0]   out_ctrl,
   output logic [2*DATA_W-1:0] out_data,
   output logic                out_noop,
   input  logic                flags_set,
   input  logic [FLAG_W-1:0]   flags_in,
   output logic [FLAG_W-1:0]   flags_out,
   output logic [1:0]          occupancy
);

   typedef struct packed {
      logic                noop;
      logic [CTRL_W-1:0]   ctrl;
      logic [2*DATA_W-1:0] data;
   } entry_t;

   entry_t in_entry;
   entry_t head;
   logic   head_valid;
   logic   push;
   logic   pop;

   // A bubble keeps its slot but carries an all-zero payload.
   always_comb begin
      in_entry = '0;
      if (in_nop) begin
         in_entry.noop = 1'b1;
      end else begin
         in_entry.ctrl = in_ctrl;
         in_entry.data = in_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flags_out <= '0;
      end else if (flags_set) begin
         flags_out <= flags_in;
      end
   end

   assign pop = head_valid && out_ready;

`ifdef PIPE_SKID_EN
   entry_t skid;
   logic   skid_valid;

   // skid_valid is a flop, so in_ready has no combinational path from out_ready.
   assign in_ready = !skid_valid;
   assign push     = in_valid && in_ready;

   // NOTE: payload registers are reset as well, since out_* must read zero during reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head       <= '0;
         head_valid <= 1'b0;
         skid       <= '0;
         skid_valid <= 1'b0;
      end else if (flush) begin
         head       <= '0;
         head_valid <= 1'b0;
         skid       <= '0;
         skid_valid <= 1'b0;
      end else if (pop || !head_valid) begin
         // Head is free this edge: refill from skid first to preserve order.
         if (skid_valid) begin
            head       <= skid;
            head_valid <= 1'b1;
         end else if (push) begin
            head       <= in_entry;
            head_valid <= 1'b1;
         end else begin
            head       <= '0;
            head_valid <= 1'b0;
         end
         skid       <= '0;
         skid_valid <= 1'b0;
      end else if (push) begin
         skid       <= in_entry;
         skid_valid <= 1'b1;
      end
   end

   assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};
`else
   assign in_ready = !head_valid || out_ready;
   assign push     = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head       <= '0;
         head_valid <= 1'b0;
      end else if (flush) begin
         head       <= '0;
         head_valid <= 1'b0;
      end else if (push) begin
         head       <= in_entry;
         head_valid <= 1'b1;
      end else if (pop) begin
         head       <= '0;
         head_valid <= 1'b0;
      end
   end

   assign occupancy = {1'b0, head_valid};
`endif

   assign out_valid = head_valid;
   assign out_ctrl  = head.ctrl;
   assign out_data  = head.data;
   assign out_noop  = head.noop;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Self-checking bench for pipeline_stage_reg: queue-based reference model plus directed literal checks.
// Follows PIPE_SKID_EN the same way as the design (two-entry vs single-entry behaviour).
module tb_pipeline_stage_reg;

   localparam int DATA_W = 16;
   localparam int CTRL_W = 8;
   localparam int FLAG_W = 3;
`ifdef PIPE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic                clk;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic                in_nop;
   logic [CTRL_W-1:0]   in_ctrl;
   logic [2*DATA_W-1:0] in_data;
   logic                flush;
   logic                out_valid;
   logic                out_ready;
   logic [CTRL_W-1:0]   out_ctrl;
   logic [2*DATA_W-1:0] out_data;
   logic                out_noop;
   logic                flags_set;
   logic [FLAG_W-1:0]   flags_in;
   logic [FLAG_W-1:0]   flags_out;
   logic [1:0]          occupancy;

   pipeline_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .FLAG_W(FLAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_nop(in_nop),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data(out_data), .out_noop(out_noop),
      .flags_set(flags_set), .flags_in(flags_in), .flags_out(flags_out),
      .occupancy(occupancy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO of held entries with capacity CAP.
   typedef struct packed {
      logic                noop;
      logic [CTRL_W-1:0]   ctrl;
      logic [2*DATA_W-1:0] data;
   } entry_t;

   entry_t            q[$];
   logic [FLAG_W-1:0] flags_m;
   bit                zero_m;

   function automatic bit model_ready();
`ifdef PIPE_SKID_EN
      return q.size() < CAP;
`else
      return q.size() == 0 || out_ready;
`endif
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         flags_m = '0;
         zero_m  = 1'b1;
      end else begin
         bit     do_push;
         bit     do_pop;
         entry_t e;
         do_push = in_valid && model_ready();
         do_pop  = q.size() != 0 && out_ready;
         e       = in_nop ? entry_t'{noop: 1'b1, ctrl: '0, data: '0}
                          : entry_t'{noop: 1'b0, ctrl: in_ctrl, data: in_data};
         if (flags_set) flags_m = flags_in;
         if (flush) begin
            q.delete();
            zero_m = 1'b1;
         end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
               q.push_back(e);
               zero_m = 1'b0;
            end
         end
      end
   end

   // Continuous comparison, away from the active edge.
   always @(negedge clk) begin
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("occupancy", 64'(occupancy), 64'(q.size()));
      check("in_ready", 64'(in_ready), 64'(model_ready()));
      check("flags_out", 64'(flags_out), 64'(flags_m));
      if (q.size() != 0) begin
         check("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
         check("out_data", 64'(out_data), 64'(q[0].data));
         check("out_noop", 64'(out_noop), 64'(q[0].noop));
      end else if (zero_m) begin
         check("cleared_ctrl", 64'(out_ctrl), 64'h0);
         check("cleared_data", 64'(out_data), 64'h0);
         check("cleared_noop", 64'(out_noop), 64'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'h0);
      check({tag, "_occ"}, 64'(occupancy), 64'h0);
      check({tag, "_data"}, 64'(out_data), 64'h0);
      check({tag, "_ctrl"}, 64'(out_ctrl), 64'h0);
      check({tag, "_noop"}, 64'(out_noop), 64'h0);
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_nop = 1'b0; in_ctrl = '0; in_data = '0;
      flush = 1'b0; out_ready = 1'b0; flags_set = 1'b0; flags_in = '0;

      // Reset state
      #3;
      check_zero_outputs("reset");
      check("reset_flags", 64'(flags_out), 64'h0);
      tick();
      #2 rst = 1'b1;
      #1 check("post_reset_in_ready", 64'(in_ready), 64'h1);

      // Basic transfer, latency one
      in_valid = 1'b1; in_data = 32'h1234_00AB; in_ctrl = 8'h5A; out_ready = 1'b1;
      tick();
      check("lat1_valid", 64'(out_valid), 64'h1);
      check("lat1_data", 64'(out_data), 64'h1234_00AB);
      check("lat1_ctrl", 64'(out_ctrl), 64'h5A);
      check("lat1_noop", 64'(out_noop), 64'h0);
      check("lat1_occ", 64'(occupancy), 64'h1);

      // Bubble entry
      in_nop = 1'b1; in_data = 32'hFFFF_FFFF; in_ctrl = 8'hFF;
      tick();
      in_valid = 1'b0; in_nop = 1'b0;
      check("nop_valid", 64'(out_valid), 64'h1);
      check("nop_ctrl", 64'(out_ctrl), 64'h0);
      check("nop_data", 64'(out_data), 64'h0);
      check("nop_noop", 64'(out_noop), 64'h1);
      tick();
      check("drain_occ", 64'(occupancy), 64'h0);

      // Stall and release: A, B, C in order
      in_valid = 1'b1; in_data = 32'hAAAA_0001; in_ctrl = 8'h01; out_ready = 1'b1;
      tick();
      in_data = 32'hBBBB_0002; in_ctrl = 8'h02; out_ready = 1'b0;
`ifdef PIPE_SKID_EN
      tick();
      check("skid_occ", 64'(occupancy), 64'h2);
      check("skid_in_ready", 64'(in_ready), 64'h0);
      check("skid_hold_a", 64'(out_data), 64'hAAAA_0001);
      in_data = 32'hCCCC_0003; in_ctrl = 8'h03;
      tick();
      check("skid_stable_a", 64'(out_data), 64'hAAAA_0001);
      check("skid_occ2", 64'(occupancy), 64'h2);
      out_ready = 1'b1;
      tick();
      check("rel_b_valid", 64'(out_valid), 64'h1);
      check("rel_b_data", 64'(out_data), 64'hBBBB_0002);
      check("rel_in_ready", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0;
      check("rel_c_valid", 64'(out_valid), 64'h1);
      check("rel_c_data", 64'(out_data), 64'hCCCC_0003);
      tick();
      check("rel_empty", 64'(occupancy), 64'h0);
`else
      #1 check("stall_in_ready", 64'(in_ready), 64'h0);
      tick();
      check("stall_hold_a", 64'(out_data), 64'hAAAA_0001);
      check("stall_occ", 64'(occupancy), 64'h1);
      out_ready = 1'b1;
      #1 check("rel_in_ready", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0;
      check("rel_b_data", 64'(out_data), 64'hBBBB_0002);
      tick();
      check("rel_empty", 64'(occupancy), 64'h0);
`endif

      // Fill, flags during stall, then flush with offered entry
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_1111; in_ctrl = 8'h11;
      flags_set = 1'b1; flags_in = 3'b010;
      tick();
      check("stall_flags", 64'(flags_out), 64'h2);
      in_data = 32'h0000_2222; in_ctrl = 8'h22; flags_set = 1'b0; flags_in = 3'b111;
      tick();
      check("full_occ", 64'(occupancy), 64'(CAP));
      check("flags_held", 64'(flags_out), 64'h2);
      flush = 1'b1; in_data = 32'hDEAD_BEEF; in_ctrl = 8'h77; out_ready = 1'b1;
      flags_set = 1'b1; flags_in = 3'b101;
      tick();
      flush = 1'b0; in_valid = 1'b0; flags_set = 1'b0; flags_in = 3'b000;
      check_zero_outputs("flush");
      check("flush_flags", 64'(flags_out), 64'h5);
      tick();
      check("flush_no_ghost", 64'(out_valid), 64'h0);
      check("flags_keep", 64'(flags_out), 64'h5);

      // Asynchronous reset mid-stream
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_3333; in_ctrl = 8'h33;
      tick();
      in_data = 32'h0000_4444; in_ctrl = 8'h44;
      tick();
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1 check_zero_outputs("async_rst");
      check("async_rst_flags", 64'(flags_out), 64'h0);
      #2 rst = 1'b1;
      #1 check("rst_rel_in_ready", 64'(in_ready), 64'h1);
      in_valid = 1'b1; in_data = 32'h0000_5555; in_ctrl = 8'h55; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("rst_rel_valid", 64'(out_valid), 64'h1);
      check("rst_rel_data", 64'(out_data), 64'h0000_5555);
      tick();

      // Randomized traffic checked by the model
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 499) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_nop    = ($urandom_range(0, 3) == 0);
         in_ctrl   = CTRL_W'($urandom());
         in_data   = (2*DATA_W)'($urandom());
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         flags_set = ($urandom_range(0, 3) == 0);
         flags_in  = FLAG_W'($urandom());
         tick();
      end
      rst = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
